// File: rtl/hypervector_demanipulator_pkg.sv
// Shared definitions for the hypervector de-manipulation decode path:
// default dimensions and the demanipulator FSM state encoding.
package hypervector_demanipulator_pkg;

  localparam int HV_DIMENSION      = 8;
  localparam int MAX_BUNDLE_CYCLES = 4;

  typedef enum logic [1:0] {
    DEMAN_IDLE   = 2'd0,
    DEMAN_ROTATE = 2'd1,
    DEMAN_DONE   = 2'd2
  } deman_state_e;

endpackage

// File: rtl/manip_onehot_encoder.sv
// Lowest-index priority encoder for one-hot manipulator codes ([0:W-1] ordering),
// flagging any code that is not exactly one-hot.
module manip_onehot_encoder #(
  parameter int MANIP_W = 4,
  parameter int CNT_W   = $clog2(MANIP_W) + 1
) (
  input  logic [0:MANIP_W-1] manip_i,
  output logic [CNT_W-1:0]   k_o,
  output logic               err_o
);

  logic [CNT_W-1:0] onesCnt;

  // Scan from the top index down so the lowest set index is the last one written.
  always_comb begin
    k_o     = '0;
    onesCnt = '0;
    for (int i = MANIP_W - 1; i >= 0; i--) begin
      if (manip_i[i]) begin
        k_o     = CNT_W'(i);
        onesCnt = onesCnt + CNT_W'(1);
      end
    end
    err_o = (onesCnt != CNT_W'(1));
  end

endmodule

// File: rtl/hypervector_demanipulator.sv
// Undoes a hypervector rotation by k, one position per cycle: out[i] = in[(i+k) mod D].
// Valid/ready on both sides; a single vector is in flight at a time.
module hypervector_demanipulator
  import hypervector_demanipulator_pkg::*;
#(
  parameter int HV_DIM  = HV_DIMENSION,
  parameter int MANIP_W = MAX_BUNDLE_CYCLES,
  parameter int CNT_W   = $clog2(MANIP_W) + 1
) (
  input  logic              Clk_CI,
  input  logic              Reset_RI,
  input  logic              ValidIn_SI,
  output logic              ReadyOut_SO,
  input  logic [0:HV_DIM-1] HypervectorIn_DI,
  input  logic [0:MANIP_W-1] ManipulatorIn_DI,
  output logic              ValidOut_SO,
  input  logic              ReadyIn_SI,
  output logic [0:HV_DIM-1] HypervectorOut_DO,
  output logic              ManipErr_SO
);

  deman_state_e      state_q;
  logic [0:HV_DIM-1] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              valid_q;
  logic [CNT_W-1:0]  encK;
  logic              encErr;

  manip_onehot_encoder #(
    .MANIP_W (MANIP_W),
    .CNT_W   (CNT_W)
  ) u_encoder (
    .manip_i (ManipulatorIn_DI),
    .k_o     (encK),
    .err_o   (encErr)
  );

  // Ready is gated by reset so it is low during reset and high right after it.
  assign ReadyOut_SO       = (state_q == DEMAN_IDLE) && !Reset_RI;
  assign ValidOut_SO       = valid_q;
  assign HypervectorOut_DO = shift_q;
  assign ManipErr_SO       = err_q;

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q <= DEMAN_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        DEMAN_IDLE: begin
          if (ValidIn_SI) begin
            shift_q <= HypervectorIn_DI;
            cnt_q   <= encK;
            err_q   <= encErr;
            if (encK != '0) begin
              state_q <= DEMAN_ROTATE;
            end else begin
              state_q <= DEMAN_DONE;
              valid_q <= 1'b1;
            end
          end
        end
        // Each step moves every bit one position toward index 0 (with wrap).
        DEMAN_ROTATE: begin
          shift_q <= {shift_q[1:HV_DIM-1], shift_q[0]};
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DEMAN_DONE;
            valid_q <= 1'b1;
          end
        end
        DEMAN_DONE: begin
          if (ReadyIn_SI) begin
            state_q <= DEMAN_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DEMAN_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
